fu_br_pred: RTL and testbench
=============================

FU_BR_PRED -- requirements
Module: fu_br_pred

Interface
REQ-001 SHALL have parameter BHT_IDX_BITS, default 8, meaning log2 of BHT/BTB entry count (index = pc[BHT_IDX_BITS+1:2]).
REQ-002 SHALL have parameter CTR_BITS, default 2, meaning width of each saturating counter (legal 1..4).
REQ-003 SHALL have clk input 1, the clock; all state on posedge clk.
REQ-004 SHALL have rst input 1, reset: synchronous, active-high.
REQ-005 SHALL have start input 1, an issue pulse qualifying rs1_v/rs2_v/decode_info this cycle.
REQ-006 SHALL have rs1_v, rs2_v input 32, the operands.
REQ-007 SHALL have decode_info input decode_info_t, carrying opcode, funct3, pc, i/j/b_imm, bp (predicted taken) and bp_addr.
REQ-008 SHALL have global_branch_signal input 1, a redirect from another FU that kills all in-flight ops.
REQ-009 SHALL have bht_raddr input BHT_IDX_BITS, the frontend lookup index.
REQ-010 SHALL have bht_taken output 1, the combinational MSB of the counter at bht_raddr.
REQ-011 SHALL have valid output 1, the result pulse; rd_v output 32, the link value.
REQ-012 SHALL have busy output 1, high while any stage holds an op.
REQ-013 SHALL have pc_select output 1 and pc_branch output 32, a redirect request and target.
REQ-014 SHALL have btb_web output 1 (active-low), btb_addr output BHT_IDX_BITS and btb_din output 32.

Function
REQ-015 SHALL be a 3-stage pipeline: S0 capture (start), S1 compute, S2 resolve; valid asserts exactly 2 cycles after start; one op accepted per cycle, no backpressure.
REQ-016 S1 SHALL compute taken/target: jal -> pc+j_imm; jalr -> (rs1+i_imm)&~1; br -> funct3 compare (beq/bne/blt/bge signed, bltu/bgeu unsigned), target pc+b_imm; rd_v = pc+4 for jal/jalr, 0 otherwise; 32-bit wrap-around.
REQ-017 S2 SHALL flag a mispredict when (taken & ~bp) | (taken & bp & bp_addr != target) | (~taken & bp); pc_select=1 then, with pc_branch = target if taken, else pc+4; otherwise pc_select=0, pc_branch=0.
REQ-018 S2 SHALL write the BTB (btb_web=0, btb_addr=pc index, btb_din=target) only when taken.
REQ-019 S2 SHALL update the BHT for op_b_br only: +1 saturating at 2^CTR_BITS-1 if taken, -1 saturating at 0 if not taken.
REQ-020 SHALL resolve a same-index BHT update and a bht_raddr read in the same cycle by returning the pre-update value.
REQ-021 SHALL kill S0/S1/S2 on global_branch_signal: killed ops assert no valid, pc_select, BTB write or BHT update; an op issued with start in the same cycle as global_branch_signal is also killed.
REQ-022 SHALL clear pc_select for the cycle after its own mispredict so that it never self-kills.
REQ-023 non-branch opcodes SHALL flow through with valid=1, pc_select=0 and no table updates.

Reset
REQ-024 rst SHALL clear all stage valids, kill bits, rd_v and pipeline registers to 0, and the BHT to weakly-not-taken (2^(CTR_BITS-1)-1); outputs SHALL read valid=0, busy=0, pc_select=0, pc_branch=0, btb_web=1, btb_addr=0, btb_din=0.
REQ-025 SHALL discard in-flight ops on rst asserted mid-operation, with no valid following.

Configuration
REQ-026 SHALL compile in the BHT with FU_BR_BHT_PRED_EN defined: the table, bht_taken and the REQ-019 updates.
REQ-027 SHALL, with FU_BR_BHT_PRED_EN undefined, synthesise no BHT storage, tie bht_taken to 0, and keep the ports unchanged.

Structure
REQ-028 decode_info_t, opcode/branch_f3 enums and a bht_ctr_t typedef SHALL reside in rv32i_types.
REQ-029 SHALL place the BHT in one sub-module, bht_sat_table (read port, update port, reset init).

Verification
REQ-030 beq rs1=rs2=5, pc=0x100, b_imm=0x20, bp=0 -> valid at cycle+2, pc_select=1, pc_branch=0x120, btb write at addr 0x40 with 0x120.
REQ-031 jal pc=0x200, j_imm=0x10, bp=1, bp_addr=0x210 -> rd_v=0x204, pc_select=0, BTB written, BHT unchanged.
REQ-032 bne rs1=rs2, bp=1, pc=0x300 -> pc_select=1, pc_branch=0x304, counter at idx 0xC0 decrements from 1 to 0, then holds at 0 on a repeat.
REQ-033 four taken blt (-1 < 1) at the same pc -> counter 1->2->3->3; bht_taken=1 after the 1st update; a same-cycle read returns the old value.
REQ-034 back-to-back starts, then global_branch_signal one cycle after the 2nd -> both killed: no valid, no BTB/BHT write, busy drops after drain.
REQ-035 rst asserted while S1 holds a taken jalr -> no valid, outputs at reset values next cycle.

Source files
------------

// File: rtl/rv32i_types.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rv32i_types : shared RV32I decode types and BHT counter helpers  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package rv32i_types;

    typedef enum logic [6:0] {
        op_b_lui   = 7'b0110111,
        op_b_auipc = 7'b0010111,
        op_b_jal   = 7'b1101111,
        op_b_jalr  = 7'b1100111,
        op_b_br    = 7'b1100011,
        op_b_load  = 7'b0000011,
        op_b_store = 7'b0100011,
        op_b_imm   = 7'b0010011,
        op_b_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_f3_t;

    // Widest legal counter; narrower tables keep the upper bits at zero.
    localparam int c_ctr_max_bits = 4;
    typedef logic [c_ctr_max_bits-1:0] bht_ctr_t;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [31:0] pc;
        logic [31:0] i_imm;
        logic [31:0] j_imm;
        logic [31:0] b_imm;
        logic        bp;
        logic [31:0] bp_addr;
    } decode_info_t;

    function automatic bht_ctr_t bht_sat_step(input bht_ctr_t ctr, input logic taken,
                                              input bht_ctr_t max);
        if (taken)
            return (ctr == max) ? ctr : ctr + bht_ctr_t'(1);
        return (ctr == '0) ? ctr : ctr - bht_ctr_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_sat_table.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bht_sat_table : table of saturating counters, 1 read + 1 update  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bht_sat_table
    import rv32i_types::*;
#(
    parameter int IDX_BITS = 8,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_taken,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
);
    localparam int       c_entries  = 1 << IDX_BITS;
    localparam bht_ctr_t c_ctr_max  = bht_ctr_t'((1 << CTR_BITS) - 1);
    localparam bht_ctr_t c_ctr_init = bht_ctr_t'((1 << (CTR_BITS - 1)) - 1);

    bht_ctr_t tbl_q [c_entries];
    bht_ctr_t upd_d;

    always_comb begin
        upd_d = bht_sat_step(tbl_q[upd_idx], upd_taken, c_ctr_max);
    end

    // Write lands on the clock edge, so a same-cycle read sees the old count.
    assign rd_taken = tbl_q[rd_idx][CTR_BITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_entries; i++)
                tbl_q[i] <= c_ctr_init;
        end else if (upd_en) begin
            tbl_q[upd_idx] <= upd_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fu_br_pred.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fu_br_pred : 3-stage branch unit, BTB write-back, optional BHT   |
// | BHT built only when FU_BR_BHT_PRED_EN is defined.  Rev 1.0       |
// +------------------------------------------------------------------+
module fu_br_pred
    import rv32i_types::*;
#(
    parameter int BHT_IDX_BITS = 8,
    parameter int CTR_BITS     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             rs1_v,
    input  logic [31:0]             rs2_v,
    input  decode_info_t            decode_info,
    input  logic                    global_branch_signal,
    input  logic [BHT_IDX_BITS-1:0] bht_raddr,
    output logic                    bht_taken,
    output logic                    valid,
    output logic [31:0]             rd_v,
    output logic                    busy,
    output logic                    pc_select,
    output logic [31:0]             pc_branch,
    output logic                    btb_web,
    output logic [BHT_IDX_BITS-1:0] btb_addr,
    output logic [31:0]             btb_din
);
    logic                    s1_valid_q, s1_valid_d;
    decode_info_t            s1_info_q, s1_info_d;
    logic [31:0]             s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d;
    logic                    s2_valid_q, s2_valid_d, s2_taken_q, s2_taken_d;
    logic                    s2_is_br_q, s2_is_br_d, s2_mis_q, s2_mis_d;
    logic [31:0]             s2_target_q, s2_target_d, s2_redir_q, s2_redir_d;
    logic [31:0]             s2_rd_q, s2_rd_d;
    logic [BHT_IDX_BITS-1:0] s2_idx_q, s2_idx_d;
    logic                    redir_q, redir_d;

    logic        w_taken, w_is_br, w_is_ctrl, w_mispred, w_live, w_btb_we, w_bht_upd;
    logic [31:0] w_target, w_link, w_pc4;

    // S1: resolve direction and target from the captured operands.
    always_comb begin
        w_taken   = 1'b0;
        w_is_br   = 1'b0;
        w_is_ctrl = 1'b0;
        w_target  = '0;
        w_link    = '0;
        w_pc4     = s1_info_q.pc + 32'd4;
        case (s1_info_q.opcode)
            op_b_jal: begin
                w_is_ctrl = 1'b1;
                w_taken   = 1'b1;
                w_target  = s1_info_q.pc + s1_info_q.j_imm;
                w_link    = w_pc4;
            end
            op_b_jalr: begin
                w_is_ctrl = 1'b1;
                w_taken   = 1'b1;
                w_target  = (s1_rs1_q + s1_info_q.i_imm) & ~32'd1;
                w_link    = w_pc4;
            end
            op_b_br: begin
                w_is_ctrl = 1'b1;
                w_is_br   = 1'b1;
                w_target  = s1_info_q.pc + s1_info_q.b_imm;
                case (branch_f3_t'(s1_info_q.funct3))
                    beq:     w_taken = (s1_rs1_q == s1_rs2_q);
                    bne:     w_taken = (s1_rs1_q != s1_rs2_q);
                    blt:     w_taken = ($signed(s1_rs1_q) <  $signed(s1_rs2_q));
                    bge:     w_taken = ($signed(s1_rs1_q) >= $signed(s1_rs2_q));
                    bltu:    w_taken = (s1_rs1_q <  s1_rs2_q);
                    bgeu:    w_taken = (s1_rs1_q >= s1_rs2_q);
                    default: w_taken = 1'b0;
                endcase
            end
            default: ;
        endcase
        w_mispred = w_is_ctrl & ((w_taken & ~s1_info_q.bp)
                               | (w_taken & s1_info_q.bp & (s1_info_q.bp_addr != w_target))
                               | (~w_taken & s1_info_q.bp));
    end

    // A redirect kills everything in flight, including an op issued this cycle.
    always_comb begin
        s1_valid_d  = start & ~global_branch_signal;
        s1_info_d   = start ? decode_info : s1_info_q;
        s1_rs1_d    = start ? rs1_v : s1_rs1_q;
        s1_rs2_d    = start ? rs2_v : s1_rs2_q;
        s2_valid_d  = s1_valid_q & ~global_branch_signal;
        s2_taken_d  = s1_valid_q ? w_taken : s2_taken_q;
        s2_is_br_d  = s1_valid_q ? w_is_br : s2_is_br_q;
        s2_mis_d    = s1_valid_q ? w_mispred : s2_mis_q;
        s2_target_d = s1_valid_q ? w_target : s2_target_q;
        s2_redir_d  = s1_valid_q ? (w_taken ? w_target : w_pc4) : s2_redir_q;
        s2_rd_d     = s1_valid_q ? w_link : s2_rd_q;
        s2_idx_d    = s1_valid_q ? s1_info_q.pc[BHT_IDX_BITS+1:2] : s2_idx_q;
        redir_d     = pc_select;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_info_q   <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_taken_q  <= 1'b0;
            s2_is_br_q  <= 1'b0;
            s2_mis_q    <= 1'b0;
            s2_target_q <= '0;
            s2_redir_q  <= '0;
            s2_rd_q     <= '0;
            s2_idx_q    <= '0;
            redir_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_info_q   <= s1_info_d;
            s1_rs1_q    <= s1_rs1_d;
            s1_rs2_q    <= s1_rs2_d;
            s2_valid_q  <= s2_valid_d;
            s2_taken_q  <= s2_taken_d;
            s2_is_br_q  <= s2_is_br_d;
            s2_mis_q    <= s2_mis_d;
            s2_target_q <= s2_target_d;
            s2_redir_q  <= s2_redir_d;
            s2_rd_q     <= s2_rd_d;
            s2_idx_q    <= s2_idx_d;
            redir_q     <= redir_d;
        end
    end

    // S2: outputs; the cycle after our own redirect must not redirect again.
    assign w_live    = s2_valid_q & ~global_branch_signal;
    assign w_btb_we  = w_live & s2_taken_q;
    assign w_bht_upd = w_live & s2_is_br_q;
    assign valid     = w_live;
    assign rd_v      = w_live ? s2_rd_q : 32'd0;
    assign busy      = s1_valid_q | s2_valid_q;
    assign pc_select = w_live & s2_mis_q & ~redir_q;
    assign pc_branch = pc_select ? s2_redir_q : 32'd0;
    assign btb_web   = ~w_btb_we;
    assign btb_addr  = w_btb_we ? s2_idx_q : '0;
    assign btb_din   = w_btb_we ? s2_target_q : 32'd0;

`ifdef FU_BR_BHT_PRED_EN
    bht_sat_table #(
        .IDX_BITS (BHT_IDX_BITS),
        .CTR_BITS (CTR_BITS)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (bht_raddr),
        .rd_taken  (bht_taken),
        .upd_en    (w_bht_upd),
        .upd_idx   (s2_idx_q),
        .upd_taken (s2_taken_q)
    );
`else
    logic w_unused_bht;
    assign w_unused_bht = ^{bht_raddr, w_bht_upd};
    assign bht_taken    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fu_br_pred.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fu_br_pred : directed vectors with a queue-based scoreboard   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_fu_br_pred;
    import rv32i_types::*;

    logic         clk = 1'b0;
    logic         rst, start, gbs;
    logic [31:0]  rs1_v, rs2_v;
    decode_info_t decode_info;
    logic [7:0]   bht_raddr;
    logic         bht_taken, valid, busy, pc_select, btb_web;
    logic [31:0]  rd_v, pc_branch, btb_din;
    logic [7:0]   btb_addr;

    fu_br_pred #(.BHT_IDX_BITS(8), .CTR_BITS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .rs1_v(rs1_v), .rs2_v(rs2_v),
        .decode_info(decode_info), .global_branch_signal(gbs), .bht_raddr(bht_raddr),
        .bht_taken(bht_taken), .valid(valid), .rd_v(rd_v), .busy(busy),
        .pc_select(pc_select), .pc_branch(pc_branch), .btb_web(btb_web),
        .btb_addr(btb_addr), .btb_din(btb_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd, br, din;
        logic        sel, web;
        logic [7:0]  addr;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic bexp(input logic v);
`ifdef FU_BR_BHT_PRED_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_bht(input string name, input logic v);
        @(negedge clk);
        chk(name, 32'(bht_taken), 32'(bexp(v)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        gbs   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive_op(input string name, input rv32i_opcode opc, input logic [2:0] f3,
                            input logic [31:0] pc, input logic [31:0] ii, input logic [31:0] jj,
                            input logic [31:0] bb, input logic bp, input logic [31:0] bpa,
                            input logic [31:0] r1, input logic [31:0] r2, input bit push,
                            input logic [31:0] e_rd, input logic e_sel, input logic [31:0] e_br,
                            input logic e_we, input logic [7:0] e_addr, input logic [31:0] e_din);
        exp_t e;
        decode_info = '{opcode: opc, funct3: f3, pc: pc, i_imm: ii, j_imm: jj,
                        b_imm: bb, bp: bp, bp_addr: bpa};
        rs1_v = r1;
        rs2_v = r2;
        start = 1'b1;
        if (push) begin
            e.name = name; e.rd = e_rd; e.sel = e_sel; e.br = e_br;
            e.web = ~e_we; e.addr = e_addr; e.din = e_din; e.cyc = cyc + 2;
            q.push_back(e);
        end
    endtask

    // Monitor: every valid pops one expectation; idle cycles must be side-effect free.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got valid=1 want no output (t=%0t)", $time);
                    end else begin
                        e = q.pop_front();
                        chk({e.name, ".latency"},   32'(cyc),       32'(e.cyc));
                        chk({e.name, ".rd_v"},      rd_v,           e.rd);
                        chk({e.name, ".pc_select"}, 32'(pc_select), 32'(e.sel));
                        chk({e.name, ".pc_branch"}, pc_branch,      e.br);
                        chk({e.name, ".btb_web"},   32'(btb_web),   32'(e.web));
                        chk({e.name, ".btb_addr"},  32'(btb_addr),  32'(e.addr));
                        chk({e.name, ".btb_din"},   btb_din,        e.din);
                    end
                end else begin
                    chk("quiet.pc_select", 32'(pc_select), 32'd0);
                    chk("quiet.btb_web",   32'(btb_web),   32'd1);
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".valid"},     32'(valid),     32'd0);
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".pc_select"}, 32'(pc_select), 32'd0);
        chk({tag, ".pc_branch"}, pc_branch,      32'd0);
        chk({tag, ".btb_web"},   32'(btb_web),   32'd1);
        chk({tag, ".btb_addr"},  32'(btb_addr),  32'd0);
        chk({tag, ".btb_din"},   btb_din,        32'd0);
        chk({tag, ".rd_v"},      rd_v,           32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; gbs = 1'b0; rs1_v = '0; rs2_v = '0;
        decode_info = '0; bht_raddr = '0;
        repeat (3) step();
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset.bht_taken", 32'(bht_taken), 32'(bexp(1'b0)));
        step();
        rst = 1'b0;
        step();

        // beq taken, predicted not-taken
        drive_op("beq_mis", op_b_br, 3'b000, 32'h100, 0, 0, 32'h20, 1'b0, 0, 5, 5, 1,
                 0, 1'b1, 32'h120, 1'b1, 8'h40, 32'h120);
        idle(4);

        // jal correctly predicted; BHT at its index must not move
        bht_raddr = 8'h80;
        drive_op("jal_hit", op_b_jal, 3'b000, 32'h200, 0, 32'h10, 0, 1'b1, 32'h210, 0, 0, 1,
                 32'h204, 1'b0, 0, 1'b1, 8'h80, 32'h210);
        idle(4);
        chk_bht("jal.bht_unchanged", 1'b0);

        // jalr with wrong predicted target, low bit cleared
        drive_op("jalr_mis", op_b_jalr, 3'b000, 32'h500, 32'h22, 0, 0, 1'b1, 32'h1000,
                 32'h1001, 0, 1, 32'h504, 1'b1, 32'h1022, 1'b1, 8'h40, 32'h1022);
        idle(4);

        // bne not-taken but predicted taken: counter 1 -> 0 -> 0
        bht_raddr = 8'hC0;
        for (int i = 0; i < 2; i++) begin
            drive_op("bne_nt", op_b_br, 3'b001, 32'h300, 0, 0, 32'h40, 1'b1, 32'h340, 7, 7, 1,
                     0, 1'b1, 32'h304, 1'b0, 8'h00, 0);
            idle(4);
            chk_bht("bne_nt.bht", 1'b0);
        end
        // two taken updates from 0 reach 2 (MSB set only after the second)
        drive_op("beq_hit", op_b_br, 3'b000, 32'h300, 0, 0, 32'h40, 1'b1, 32'h340, 7, 7, 1,
                 0, 1'b0, 0, 1'b1, 8'hC0, 32'h340);
        idle(4);
        chk_bht("ctr_0_to_1", 1'b0);
        drive_op("beq_hit", op_b_br, 3'b000, 32'h300, 0, 0, 32'h40, 1'b1, 32'h340, 7, 7, 1,
                 0, 1'b0, 0, 1'b1, 8'hC0, 32'h340);
        idle(4);
        chk_bht("ctr_1_to_2", 1'b1);

        // four taken blt at idx 1: 1->2->3->3, same-cycle read sees the old value
        bht_raddr = 8'h01;
        drive_op("blt_t", op_b_br, 3'b100, 32'h404, 0, 0, 32'h8, 1'b0, 0, 32'hFFFF_FFFF, 1, 1,
                 0, 1'b1, 32'h40C, 1'b1, 8'h01, 32'h40C);
        step();
        step();
        chk_bht("blt1.same_cycle_old", 1'b0);
        step();
        chk_bht("blt1.after_update", 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            drive_op("blt_t", op_b_br, 3'b100, 32'h404, 0, 0, 32'h8, 1'b0, 0, 32'hFFFF_FFFF, 1, 1,
                     0, 1'b1, 32'h40C, 1'b1, 8'h01, 32'h40C);
            idle(4);
            chk_bht("blt_rep.bht", 1'b1);
        end
        // saturated at 3: two not-taken bge go 3->2->1
        drive_op("bge_nt", op_b_br, 3'b101, 32'h404, 0, 0, 32'h8, 1'b0, 0, 32'hFFFF_FFFF, 1, 1,
                 0, 1'b0, 0, 1'b0, 8'h00, 0);
        idle(4);
        chk_bht("sat_3_to_2", 1'b1);
        drive_op("bge_nt", op_b_br, 3'b101, 32'h404, 0, 0, 32'h8, 1'b0, 0, 32'hFFFF_FFFF, 1, 1,
                 0, 1'b0, 0, 1'b0, 8'h00, 0);
        idle(4);
        chk_bht("sat_2_to_1", 1'b0);

        // unsigned compares, negative offset, pc wrap, non-branch pass-through
        drive_op("bltu_hit", op_b_br, 3'b110, 32'h600, 0, 0, 32'hFFFF_FFF0, 1'b1, 32'h5F0,
                 1, 32'hFFFF_FFFF, 1, 0, 1'b0, 0, 1'b1, 8'h80, 32'h5F0);
        idle(4);
        drive_op("bgeu_nt", op_b_br, 3'b111, 32'h600, 0, 0, 32'hFFFF_FFF0, 1'b0, 0,
                 1, 32'hFFFF_FFFF, 1, 0, 1'b0, 0, 1'b0, 8'h00, 0);
        idle(4);
        drive_op("jal_wrap", op_b_jal, 3'b000, 32'hFFFF_FFF8, 0, 32'h10, 0, 1'b0, 0, 0, 0, 1,
                 32'hFFFF_FFFC, 1'b1, 32'h8, 1'b1, 8'hFE, 32'h8);
        idle(4);
        drive_op("alu_pass", op_b_imm, 3'b000, 32'h800, 0, 0, 0, 1'b1, 32'h900, 3, 4, 1,
                 0, 1'b0, 0, 1'b0, 8'h00, 0);
        idle(4);

        // back-to-back mispredicts: the second redirect is suppressed
        drive_op("b2b_a", op_b_br, 3'b000, 32'h708, 0, 0, 32'h10, 1'b0, 0, 1, 1, 1,
                 0, 1'b1, 32'h718, 1'b1, 8'hC2, 32'h718);
        step();
        drive_op("b2b_b", op_b_br, 3'b000, 32'h70C, 0, 0, 32'h10, 1'b0, 0, 1, 1, 1,
                 0, 1'b0, 0, 1'b1, 8'hC3, 32'h71C);
        idle(4);

        // kill: two in flight plus one issued alongside the redirect
        bht_raddr = 8'h01;
        drive_op("kill_a", op_b_br, 3'b100, 32'h404, 0, 0, 32'h8, 1'b0, 0, 32'hFFFF_FFFF, 1, 0,
                 0, 1'b0, 0, 1'b0, 8'h00, 0);
        step();
        drive_op("kill_b", op_b_br, 3'b100, 32'h404, 0, 0, 32'h8, 1'b0, 0, 32'hFFFF_FFFF, 1, 0,
                 0, 1'b0, 0, 1'b0, 8'h00, 0);
        @(negedge clk);
        chk("kill.busy_inflight", 32'(busy), 32'd1);
        step();
        gbs = 1'b1;
        drive_op("kill_c", op_b_br, 3'b100, 32'h404, 0, 0, 32'h8, 1'b0, 0, 32'hFFFF_FFFF, 1, 0,
                 0, 1'b0, 0, 1'b0, 8'h00, 0);
        step();
        @(negedge clk);
        chk("kill.busy_drained", 32'(busy), 32'd0);
        idle(3);
        chk_bht("kill.bht_unchanged", 1'b0);

        // reset while S1 holds a taken jalr
        bht_raddr = 8'hC0;
        chk_bht("pre_rst.bht", 1'b1);
        drive_op("rst_jalr", op_b_jalr, 3'b000, 32'h900, 32'h4, 0, 0, 1'b0, 0, 32'h2000, 0, 0,
                 0, 1'b0, 0, 1'b0, 8'h00, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_rst");
        chk("mid_rst.bht_taken", 32'(bht_taken), 32'(bexp(1'b0)));
        idle(4);

        for (int i = 0; i < 50 && q.size() != 0; i++) step();
        chk("drain.queue_empty", 32'(q.size()), 32'd0);
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
